// File: rtl/id_hazard_unit.sv
// id_hazard_unit
// Decode-stage data hazard tracker. A shadow pipeline records the destination
// register of every in-flight instruction from EX (entry 0) through WB
// (entry DEPTH-1). Each cycle the decode instruction's source registers are
// compared against that shadow pipeline. The result is either a stall request
// or, when forwarding is enabled, a per-operand forwarding source select.
//
// Handshake: there is no valid/ready pair. id_valid_inst qualifies the decode
// instruction. advance=1 means the whole pipeline moves on this clock edge,
// and advance=0 freezes it. stall is a same-cycle combinational request: when
// it is high the decode instruction is not issued and a bubble enters the
// tracker.
module id_hazard_unit #(
    parameter int IDX_W       = 5,
    parameter int DEPTH       = 3,
    parameter int FWD_EN      = 0,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 32,
    localparam int SW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_inst,
    input  logic [31:0]      id_inst,
    input  logic             id_reg_wr,
    input  logic [IDX_W-1:0] id_dest_reg_idx,
    input  logic             id_rd_mem,
    input  logic             advance,
    input  logic             flush,
    output logic             stall,
    output logic [SW-1:0]    fwd_a_sel,
    output logic [SW-1:0]    fwd_b_sel,
    output logic [CNT_W-1:0] stall_count
);

    // Opcodes whose source fields are meaningful.
    localparam logic [6:0] OP_R_TYPE  = 7'b0110011;
    localparam logic [6:0] OP_B_TYPE  = 7'b1100011;
    localparam logic [6:0] OP_S_TYPE  = 7'b0100011;
    localparam logic [6:0] OP_I_ARITH = 7'b0010011;
    localparam logic [6:0] OP_I_LD    = 7'b0000011;
    localparam logic [6:0] OP_I_JAL   = 7'b1100111;

    // Shadow pipeline: valid, destination index, and a load flag per stage.
    logic [DEPTH-1:0] r_v;
    logic [IDX_W-1:0] r_idx [DEPTH];
    logic [DEPTH-1:0] r_ld;
    logic [CNT_W-1:0] r_stall_cnt;

    // Source decode.
    logic [6:0]       w_opcode;
    logic             w_src_en  [2];
    logic [IDX_W-1:0] w_src     [2];

    // Youngest-match search results per source.
    logic             w_hit     [2];
    logic [SW-1:0]    w_hit_sel [2];
    logic             w_hit_ld  [2];

    // Per-source hazard and forwarding select.
    logic             w_haz     [2];
    logic [SW-1:0]    w_sel     [2];

    logic             w_stall;
    logic             w_issue;
    logic             w_unused_inst_bits;

    assign w_opcode = id_inst[6:0];

    // These instruction bits never select a source register.
    assign w_unused_inst_bits = ^{id_inst[31:25], id_inst[14:12], id_inst[11:7]};

    // Work out which source fields the decode instruction actually reads.
    always_comb begin
        w_src_en[0] = 1'b0;
        w_src_en[1] = 1'b0;
        w_src[0]    = IDX_W'(id_inst[19:15]);
        w_src[1]    = IDX_W'(id_inst[24:20]);
        case (w_opcode)
            OP_R_TYPE, OP_B_TYPE, OP_S_TYPE: begin
                w_src_en[0] = 1'b1;
                w_src_en[1] = 1'b1;
            end
            OP_I_ARITH, OP_I_LD, OP_I_JAL: begin
                w_src_en[0] = 1'b1;
            end
            default: begin
                w_src_en[0] = 1'b0;
                w_src_en[1] = 1'b0;
            end
        endcase
    end

    // Find the youngest tracker entry that writes each source. The scan runs
    // from oldest to youngest, so the youngest match overwrites older ones.
    // x0 is hard-wired to zero and therefore never matches.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_hit[s]     = 1'b0;
            w_hit_sel[s] = '0;
            w_hit_ld[s]  = 1'b0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (w_src_en[s] && (w_src[s] != '0) && r_v[k] &&
                    (r_idx[k] == w_src[s])) begin
                    w_hit[s]     = 1'b1;
                    w_hit_sel[s] = SW'(k + 1);
                    w_hit_ld[s]  = r_ld[k];
                end
            end
        end
    end

    // Decide hazard or forwarding per source. Without forwarding, every match
    // stalls, because the register file does not write through. With
    // forwarding, only a load still in EX stalls, since its data is not
    // available until the next stage.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            w_haz[s] = 1'b0;
            w_sel[s] = '0;
            if (w_hit[s]) begin
                if (FWD_EN == 0) begin
                    w_haz[s] = 1'b1;
                end else if ((w_hit_sel[s] == SW'(1)) && w_hit_ld[s]) begin
                    w_haz[s] = 1'b1;
                end else begin
                    w_sel[s] = w_hit_sel[s];
                end
            end
        end
    end

    // A flush squashes the decode instruction, so it overrides any stall.
    assign w_stall = id_valid_inst & ~flush & (w_haz[0] | w_haz[1]);

    // Only instructions that write a nonzero register occupy the tracker.
    assign w_issue = id_valid_inst & ~w_stall & ~flush & id_reg_wr &
                     (id_dest_reg_idx != '0);

    assign stall       = w_stall;
    assign fwd_a_sel   = (w_stall || !id_valid_inst) ? '0 : w_sel[0];
    assign fwd_b_sel   = (w_stall || !id_valid_inst) ? '0 : w_sel[1];
    assign stall_count = r_stall_cnt;

    // Shift the shadow pipeline on advance. A flush invalidates the youngest
    // FLUSH_DEPTH slots, whether the pipeline shifts or is frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v  <= '0;
            r_ld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_idx[k] <= '0;
            end
        end else if (advance) begin
            r_v[0]   <= w_issue;
            r_idx[0] <= id_dest_reg_idx;
            r_ld[0]  <= id_rd_mem;
            for (int k = 1; k < DEPTH; k++) begin
                if (flush && (k < FLUSH_DEPTH)) begin
                    r_v[k] <= 1'b0;
                end else begin
                    r_v[k] <= r_v[k-1];
                end
                r_idx[k] <= r_idx[k-1];
                r_ld[k]  <= r_ld[k-1];
            end
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (k < FLUSH_DEPTH) begin
                    r_v[k] <= 1'b0;
                end
            end
        end
    end

    // Count stalled cycles in which the pipeline actually moved, saturating
    // at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && advance && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
